// File: rtl/axi_rob_pkg.sv
// Shared types and default widths for the AXI reorder-buffer request and response paths.
package axi_rob_pkg;

   localparam int unsigned AXI_ID_W   = 8;
   localparam int unsigned AXI_DATA_W = 64;
   localparam int unsigned AXI_RESP_W = 2;

   typedef struct packed {
      logic [AXI_ID_W-1:0]   id;
      logic [AXI_DATA_W-1:0] data;
      logic [AXI_RESP_W-1:0] resp;
      logic                  last;
   } r_entry_t;

endpackage

// File: rtl/rob_fifo_ctrl.sv
// Circular-buffer controller: read/write pointers with arbitrary-DEPTH wrap, occupancy, full/empty.
// Callers must never push when full or pop when empty.
module rob_fifo_ctrl #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
   output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
   output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int unsigned      PTR_W    = $clog2(DEPTH);
   localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] occ_q, occ_d;

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] n;
      if (p == LAST_IDX) begin
         n = {PTR_W{1'b0}};
      end else begin
         n = p + PTR_W'(1);
      end
      return n;
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push_i) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
         2'b10:   occ_d = occ_q + CNT_W'(1);
         2'b01:   occ_d = occ_q - CNT_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         occ_q    <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign wr_ptr_o    = wr_ptr_q;
   assign rd_ptr_o    = rd_ptr_q;
   assign occupancy_o = occ_q;
   assign full_o      = (occ_q == FULL_CNT);
   assign empty_o     = (occ_q == {CNT_W{1'b0}});

endmodule

// File: rtl/outgoing_response_buffer.sv
// AXI R-beat return buffer: strict FIFO with optional store-and-forward release per burst,
// falling back to cut-through when a single burst fills the whole buffer.
module outgoing_response_buffer
   import axi_rob_pkg::*;
#(
   parameter int unsigned ID_WIDTH          = AXI_ID_W,
   parameter int unsigned DATA_WIDTH        = AXI_DATA_W,
   parameter int unsigned RESP_WIDTH        = AXI_RESP_W,
   parameter int unsigned DEPTH             = 16,
   parameter bit          STORE_AND_FORWARD = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       r_in_valid_i,
   output logic                       r_in_ready_o,
   input  logic [ID_WIDTH-1:0]        r_in_id_i,
   input  logic [DATA_WIDTH-1:0]      r_in_data_i,
   input  logic [RESP_WIDTH-1:0]      r_in_resp_i,
   input  logic                       r_in_last_i,
   output logic                       r_out_valid_o,
   input  logic                       r_out_ready_i,
   output logic [ID_WIDTH-1:0]        r_out_id_o,
   output logic [DATA_WIDTH-1:0]      r_out_data_o,
   output logic [RESP_WIDTH-1:0]      r_out_resp_o,
   output logic                       r_out_last_o,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [$clog2(DEPTH+1)-1:0] cmpl_bursts,
   output logic                       cut_through
);
   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
   localparam int unsigned ENTRY_W = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + 1;
   localparam logic        SAF     = STORE_AND_FORWARD;

   logic               push_s, pop_s, full_s, empty_s;
   logic               burst_inc_s, burst_dec_s, ct_set_s;
   logic [PTR_W-1:0]   wr_ptr_s, rd_ptr_s;
   logic [CNT_W-1:0]   occ_s;
   logic [CNT_W-1:0]   cmpl_q, cmpl_d;
   logic               ct_q, ct_d;
   logic [ENTRY_W-1:0] mem_q [DEPTH];

   rob_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push_s),
      .pop_i       (pop_s),
      .wr_ptr_o    (wr_ptr_s),
      .rd_ptr_o    (rd_ptr_s),
      .occupancy_o (occ_s),
      .full_o      (full_s),
      .empty_o     (empty_s)
   );

   // Ready never looks at r_out_ready, so a full buffer refuses a beat even on a same-cycle pop.
   assign r_in_ready_o = ~full_s;
   assign push_s       = r_in_valid_i & r_in_ready_o;
   assign pop_s        = r_out_valid_o & r_out_ready_i;

   // Payload storage is deliberately left uninitialised by reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_s] <= {r_in_id_i, r_in_data_i, r_in_resp_i, r_in_last_i};
      end
   end

   assign {r_out_id_o, r_out_data_o, r_out_resp_o, r_out_last_o} = mem_q[rd_ptr_s];

   // Valid stays stable until popped: cmpl_q only drops on a pop, ct_q only clears on a last pop.
   assign r_out_valid_o = SAF ? (~empty_s & ((|cmpl_q) | ct_q | full_s)) : ~empty_s;

   always_comb begin
      burst_inc_s = push_s & r_in_last_i;
      burst_dec_s = pop_s & r_out_last_o;
      ct_set_s    = SAF & full_s & ~(|cmpl_q);
      cmpl_d      = cmpl_q;
      ct_d        = ct_q;
      case ({burst_inc_s, burst_dec_s})
         2'b10:   cmpl_d = cmpl_q + CNT_W'(1);
         2'b01:   cmpl_d = cmpl_q - CNT_W'(1);
         default: cmpl_d = cmpl_q;
      endcase
      if (burst_dec_s) begin
         ct_d = 1'b0;
      end else if (ct_set_s) begin
         ct_d = 1'b1;
      end else begin
         ct_d = ct_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmpl_q <= {CNT_W{1'b0}};
         ct_q   <= 1'b0;
      end else begin
         cmpl_q <= cmpl_d;
         ct_q   <= ct_d;
      end
   end

   assign occupancy   = occ_s;
   assign cmpl_bursts = cmpl_q;
   assign cut_through = ct_q;

endmodule

// File: tb/tb_outgoing_response_buffer.sv
// Scoreboard bench for outgoing_response_buffer against a queue-based burst-release model.
module tb_outgoing_response_buffer;
   localparam int unsigned DEPTH = 16;
   localparam bit          SAF   = 1'b1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             r_in_valid_i = 1'b0;
   logic             r_in_ready_o;
   logic [7:0]       r_in_id_i = 8'h00;
   logic [63:0]      r_in_data_i = 64'h0;
   logic [1:0]       r_in_resp_i = 2'b00;
   logic             r_in_last_i = 1'b0;
   logic             r_out_valid_o;
   logic             r_out_ready_i = 1'b0;
   logic [7:0]       r_out_id_o;
   logic [63:0]      r_out_data_o;
   logic [1:0]       r_out_resp_o;
   logic             r_out_last_o;
   logic [CNT_W-1:0] occupancy;
   logic [CNT_W-1:0] cmpl_bursts;
   logic             cut_through;

   outgoing_response_buffer #(
      .ID_WIDTH(8), .DATA_WIDTH(64), .RESP_WIDTH(2), .DEPTH(DEPTH), .STORE_AND_FORWARD(SAF)
   ) dut (
      .clk(clk), .rst(rst),
      .r_in_valid_i(r_in_valid_i), .r_in_ready_o(r_in_ready_o), .r_in_id_i(r_in_id_i),
      .r_in_data_i(r_in_data_i), .r_in_resp_i(r_in_resp_i), .r_in_last_i(r_in_last_i),
      .r_out_valid_o(r_out_valid_o), .r_out_ready_i(r_out_ready_i), .r_out_id_o(r_out_id_o),
      .r_out_data_o(r_out_data_o), .r_out_resp_o(r_out_resp_o), .r_out_last_o(r_out_last_o),
      .occupancy(occupancy), .cmpl_bursts(cmpl_bursts), .cut_through(cut_through)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   beat_t       mq[$];
   bit          m_ct = 1'b0;
   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;
   bit          drv_done = 1'b0;

   function automatic int unsigned m_nlast();
      int unsigned n = 0;
      foreach (mq[i]) if (mq[i].last) n++;
      return n;
   endfunction

   // A beat may leave when a whole burst is held, the buffer is full, or forced cut-through is on.
   function automatic bit m_valid();
      if (mq.size() == 0) return 1'b0;
      if (!SAF) return 1'b1;
      return (m_nlast() != 0) || m_ct || (mq.size() == DEPTH);
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model step on each active edge, using the model's own view of ready/valid.
   initial forever begin
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_ct = 1'b0;
      end else begin
         int unsigned sz, nl;
         bit          pu, po;
         beat_t       b;
         sz = mq.size();
         nl = m_nlast();
         pu = r_in_valid_i && (sz < DEPTH);
         po = m_valid() && r_out_ready_i;
         if (po && mq[0].last) m_ct = 1'b0;
         else if (SAF && sz == DEPTH && nl == 0) m_ct = 1'b1;
         if (po) void'(mq.pop_front());
         if (pu) begin
            b.id = r_in_id_i; b.data = r_in_data_i; b.resp = r_in_resp_i; b.last = r_in_last_i;
            mq.push_back(b);
         end
      end
   end

   // Monitor: compares status every cycle and the head beat whenever a pop is presented.
   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", r_in_ready_o, mq.size() < DEPTH);
         chk("out_valid", r_out_valid_o, m_valid());
         chk("occupancy", occupancy, mq.size());
         chk("cmpl_bursts", cmpl_bursts, m_nlast());
         chk("cut_through", cut_through, m_ct);
         if (r_out_valid_o && r_out_ready_i && mq.size() > 0)
            chk("payload", {r_out_id_o, r_out_data_o, r_out_resp_o, r_out_last_o},
                {mq[0].id, mq[0].data, mq[0].resp, mq[0].last});
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [7:0] id, input logic [63:0] data,
                            input logic [1:0] resp, input logic last);
      bit rdy;
      bit acc = 1'b0;
      r_in_valid_i = 1'b1;
      r_in_id_i = id; r_in_data_i = data; r_in_resp_i = resp; r_in_last_i = last;
      for (int k = 0; k < 400 && !acc; k++) begin
         @(negedge clk);
         rdy = r_in_ready_o;
         @(posedge clk);
         #1;
         acc = rdy;
      end
      if (!acc) begin
         n_cmp++; n_fail++;
         $display("FAIL push_timeout: beat data=%0h never accepted", data);
      end
   endtask

   task automatic reset_checks();
      @(negedge clk);
      chk("rst_in_ready", r_in_ready_o, 1'b1);
      chk("rst_out_valid", r_out_valid_o, 1'b0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_cmpl", cmpl_bursts, 0);
      chk("rst_cut_through", cut_through, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      reset_checks();
      cycles(2);

      // Store-and-forward burst of four beats.
      r_out_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) send_beat(8'h3, 64'(i), 2'b00, i == 3);
      r_in_valid_i = 1'b0;
      cycles(8);

      // Fill with single-beat bursts, hold valid while full, then drain through a wrap.
      r_out_ready_i = 1'b0;
      for (int i = 0; i < 16; i++) send_beat(8'(i), 64'(i), 2'(i), 1'b1);
      r_in_valid_i = 1'b1; r_in_data_i = 64'd16; r_in_last_i = 1'b1;
      cycles(3);
      chk("full_occupancy", occupancy, 16);
      r_out_ready_i = 1'b1;
      for (int i = 16; i < 21; i++) send_beat(8'(i), 64'(i), 2'(i), 1'b1);
      r_in_valid_i = 1'b0;
      cycles(25);

      // Burst longer than DEPTH forces cut-through.
      for (int i = 0; i < 20; i++) send_beat(8'h5, 64'(100 + i), 2'b01, i == 19);
      r_in_valid_i = 1'b0;
      cycles(25);
      chk("ct_cleared", cut_through, 1'b0);

      // Push a last beat while a last beat is popped.
      r_out_ready_i = 1'b0;
      send_beat(8'h7, 64'hA, 2'b00, 1'b1);
      send_beat(8'h7, 64'hB, 2'b00, 1'b0);
      send_beat(8'h7, 64'hC, 2'b00, 1'b0);
      r_out_ready_i = 1'b1;
      send_beat(8'h8, 64'hD, 2'b00, 1'b1);
      r_out_ready_i = 1'b0;
      r_in_valid_i = 1'b0;
      chk("simul_occupancy", occupancy, 3);
      chk("simul_cmpl", cmpl_bursts, 1);
      cycles(2);
      r_out_ready_i = 1'b1;
      cycles(6);

      // Reset with seven beats stored and cut-through active.
      r_out_ready_i = 1'b0;
      for (int i = 0; i < 16; i++) send_beat(8'h9, 64'(200 + i), 2'b10, 1'b0);
      r_in_valid_i = 1'b0;
      cycles(2);
      r_out_ready_i = 1'b1;
      cycles(9);
      r_out_ready_i = 1'b0;
      cycles(1);
      chk("pre_rst_occupancy", occupancy, 7);
      chk("pre_rst_ct", cut_through, 1'b1);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      reset_checks();

      // Randomised bursts against random back-pressure.
      fork
         begin
            repeat (60) begin
               int unsigned len;
               len = ($urandom_range(0, 9) == 0) ? $urandom_range(17, 22) : $urandom_range(1, 6);
               for (int b = 0; b < int'(len); b++)
                  send_beat(8'($urandom_range(0, 255)), {$urandom(), $urandom()},
                            2'($urandom_range(0, 3)), b == int'(len) - 1);
               if ($urandom_range(0, 2) == 0) begin
                  r_in_valid_i = 1'b0;
                  cycles($urandom_range(1, 3));
               end
            end
            r_in_valid_i = 1'b0;
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(posedge clk);
               #1 r_out_ready_i = ($urandom_range(0, 3) != 0);
            end
         end
      join
      r_out_ready_i = 1'b1;
      cycles(60);
      chk("final_occupancy", occupancy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
